// File: rtl/div_unit_if.sv
// Operand/result bundle between the execute stage and the iterative divider.
interface div_unit_if #(
    parameter int size = 32
) ();
    logic            start;
    logic [1:0]      op;
    logic [size-1:0] A;
    logic [size-1:0] B;
    logic            flush;
    logic            busy;
    logic            done;
    logic [size-1:0] S;

    // Requester side: drives the request and operands, observes status/result.
    modport master (
        output start, op, A, B, flush,
        input  busy, done, S
    );

    // Divider side: consumes the request, produces status/result.
    modport slave (
        input  start, op, A, B, flush,
        output busy, done, S
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; sign fix-up in FIX; DONE pulses the result.
module div_unit #(
    parameter int size = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(size + 1);

    localparam logic [size-1:0]  ZERO     = {size{1'b0}};
    localparam logic [size-1:0]  ONES     = {size{1'b1}};
    localparam logic [size-1:0]  ONE      = {{(size-1){1'b0}}, 1'b1};
    localparam logic [size-1:0]  MOST_NEG = {1'b1, {(size-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(size);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] dvd_q, dvd_d;       // dividend, becomes quotient as bits shift in
    logic [size-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [size-1:0] rem_q, rem_d;       // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;      // iterations left
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;
    logic            sel_rem_q, sel_rem_d; // op[1]: return remainder instead of quotient
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [size-1:0] s_q, s_d;

    logic            accept_s;
    logic            signed_op_s;
    logic            div0_s;
    logic            ovf_s;
    logic            special_s;
    logic [size-1:0] special_res_s;
    logic [size-1:0] abs_a_s;
    logic [size-1:0] abs_b_s;
    logic [size:0]   rem_sh_s;
    logic [size:0]   trial_s;
    logic [size-1:0] q_fix_s;
    logic [size-1:0] r_fix_s;

    // Request decode and special-case detection on the raw operands.
    always_comb begin
        accept_s    = (state_q == IDLE) && bus.start && !bus.flush;
        signed_op_s = ~bus.op[0];
        div0_s      = (bus.B == ZERO);
        ovf_s       = signed_op_s && (bus.A == MOST_NEG) && (bus.B == ONES);
        special_s   = div0_s || ovf_s;
        if (div0_s) begin
            special_res_s = bus.op[1] ? bus.A : ONES;
        end else begin
            special_res_s = bus.op[1] ? ZERO : bus.A;
        end
        // |MOST_NEG| wraps to the same bit pattern, which is correct read as unsigned.
        abs_a_s = (signed_op_s && bus.A[size-1]) ? (~bus.A + ONE) : bus.A;
        abs_b_s = (signed_op_s && bus.B[size-1]) ? (~bus.B + ONE) : bus.B;
    end

    // One restoring step plus the sign fix-up values used in FIX.
    always_comb begin
        rem_sh_s = {rem_q, dvd_q[size-1]};
        // rem_q < dvs_q keeps the result within size+1 bits, so bit [size] is the sign.
        trial_s  = rem_sh_s - {1'b0, dvs_q};
        q_fix_s  = qsign_q ? (~dvd_q + ONE) : dvd_q;
        r_fix_s  = rsign_q ? (~rem_q + ONE) : rem_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything except reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = special_s ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: operand capture on accept, one shift per CALC cycle.
    always_comb begin
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        sel_rem_d = sel_rem_q;
        if (accept_s) begin
            sel_rem_d = bus.op[1];
            if (!special_s) begin
                dvd_d   = abs_a_s;
                dvs_d   = abs_b_s;
                rem_d   = ZERO;
                cnt_d   = CNT_LOAD;
                qsign_d = signed_op_s && (bus.A[size-1] ^ bus.B[size-1]);
                rsign_d = signed_op_s && bus.A[size-1];
            end else begin
                dvd_d = dvd_q;
            end
        end else if ((state_q == CALC) && !bus.flush) begin
            rem_d = trial_s[size] ? rem_sh_s[size-1:0] : trial_s[size-1:0];
            dvd_d = {dvd_q[size-2:0], ~trial_s[size]};
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q     <= ZERO;
            dvs_q     <= ZERO;
            rem_q     <= ZERO;
            cnt_q     <= CNT_ZERO;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    // Output next values; busy/done follow the state being entered so they are registered.
    always_comb begin
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
        if (accept_s && special_s) begin
            s_d = special_res_s;
        end else if ((state_q == FIX) && !bus.flush) begin
            s_d = sel_rem_q ? r_fix_s : q_fix_s;
        end else begin
            s_d = s_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            s_q    <= ZERO;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            s_q    <= s_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed + random bench for div_unit with an expected-result scoreboard.
module tb_div_unit;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;
    logic [31:0] sb_q[$];

    div_unit_if #(.size(32)) bus ();

    div_unit #(.size(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = op[1] ? 32'd0 : a;
        end else begin
            case (op)
                2'b00:   r = $signed(a) / $signed(b);
                2'b01:   r = a / b;
                2'b10:   r = $signed(a) % $signed(b);
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    // Issue one operation at cycle 0, wait for done, check latency, busy and result.
    // inj_cyc > 0 pulses a stray start (A=9, B=3) in that cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_s,
                          input int exp_lat, input int inj_cyc);
        int cyc;
        bit got;
        logic [31:0] exp_pop;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        sb_q.push_back(exp_s);
        cyc = 0;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == inj_cyc) begin
                bus.start = 1'b1;
                bus.A     = 32'd9;
                bus.B     = 32'd3;
            end
            if (exp_lat > 1 && (cyc == 1 || cyc == exp_lat - 1)) begin
                chk({tag, "_busy_mid"}, {31'd0, bus.busy}, 32'd1);
            end
            if (bus.done === 1'b1) got = 1'b1;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        exp_pop = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        if (got) begin
            chk({tag, "_S"}, bus.S, exp_pop);
            chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
            chk({tag, "_S_hold"}, bus.S, exp_pop);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic watch_no_done(input string tag, input int ncyc);
        int pulses;
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk({tag, "_no_done"}, pulses, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        int          rlat;
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_S", bus.S, 32'd0);
        reset = 1'b0;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
        run_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_op("div_min_2",  2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, 0);
        run_op("divu_big",   2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 0);
        run_op("rem_m8_4",   2'b10, 32'hFFFF_FFF8, 32'd4, 32'd0, 34, 0);

        // Start while busy must be ignored.
        run_op("divu_ignore", 2'b01, 32'd100, 32'd7, 32'd14, 34, 10);

        // Flush during CALC: back to IDLE, no done, S keeps the previous result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.A     = 32'd9;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_done", {31'd0, bus.done}, 32'd0);
        chk("flush_S", bus.S, 32'd14);
        watch_no_done("flush", 40);
        chk("flush_S_after", bus.S, 32'd14);

        // Flush in IDLE blocks a same-cycle start.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
        watch_no_done("flush_idle", 40);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_S", bus.S, 32'd0);
        watch_no_done("midrst", 40);
        run_op("after_rst", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0);

        // Random operations against the behavioural model.
        for (int k = 0; k < 8; k++) begin
            ra   = $urandom;
            rb   = (k == 3) ? 32'd0 : ($urandom >> (k * 3));
            rop  = 2'($urandom_range(0, 3));
            rlat = (rb == 32'd0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34;
            run_op($sformatf("rand%0d", k), rop, ra, rb, ref_div(rop, ra, rb), rlat, 0);
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divide/remainder unit for the execute stage; implements RV32M DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU and takes operands from the same A/B operand path.
- Executes a restoring radix-2 divide, one quotient bit per cycle.
- The pipeline stalls on busy and captures the result on done.

Parameters:
- size, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- A  input  size  dividend; sampled on accepted start.
- B  input  size  divisor; sampled on accepted start.
- flush  input  1  aborts any operation in progress.
- busy  output  1  high from the cycle after accept until done is asserted (inclusive of CALC/FIX).
- done  output  1  single-cycle pulse; S is valid in that cycle.
- S  output  size  result; held stable after done until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). On reset:
  - State goes to IDLE.
  - busy=0, done=0, S=0.
  - The internal quotient, remainder and counter registers clear.
  - Reset mid-operation discards the operation; done is never pulsed for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1 and flush=0, latch op, A and B, and compute special cases, all in one cycle.
  - Divide by zero (B==0):
    - Quotient result is all ones.
    - Remainder result is A.
    - Go directly to DONE.
  - Signed overflow (op DIV/REM, A==100..0, B==all ones):
    - Quotient result is A.
    - Remainder result is 0.
    - Go directly to DONE.
  - Otherwise:
    - Store |A| and |B| for signed ops; raw values for unsigned ops.
    - Record quotient sign (A[msb]^B[msb]) and remainder sign (A[msb]), signed ops only.
    - Clear the remainder register, load the counter with size, go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem, dividend} left by one.
  - trial = rem - divisor, computed size+1 bits wide.
  - If trial is non-negative: rem=trial, and shift in quotient bit 1; else keep rem and shift in 0.
  - Decrement the counter; after exactly size iterations go to FIX.
- FIX:
  - Negate the quotient if its sign flag is set.
  - Negate the remainder if its sign flag is set.
  - Select the quotient for op[1]=0 and the remainder for op[1]=1; register into S.
  - Go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
  - start in the DONE cycle is ignored; the requester retries in IDLE.
- Latency (start accepted at cycle 0):
  - Normal case: done is high in cycle size+2, i.e. 34 for size=32.
  - Special cases: done is high in cycle 1.
- busy:
  - 1 in CALC and FIX; 0 in IDLE and DONE.
  - start while busy=1 is ignored; the latched operands are unaffected.
- flush:
  - In CALC or FIX: return to IDLE next cycle, no done, S unchanged.
  - In IDLE: blocks acceptance of start in the same cycle.
  - reset has priority over flush; flush has priority over start.
- Arithmetic:
  - Magnitudes are computed in size bits; |100..0| is representable as unsigned 100..0 and needs no special handling.
  - Remainder sign follows the dividend; a zero result is never negated to a nonzero value.

Test Plan:
- DIVU A=100, B=7, start at cycle 0 -> busy=1 in cycles 1..33, done=1 with S=14 in cycle 34; REMU with the same operands -> S=2.
- DIV A=-7 (0xFFFFFFF9), B=2 -> S=0xFFFFFFFD (-3); REM -> S=0xFFFFFFFF (-1); REM A=7, B=-2 -> S=1.
- DIV A=5, B=0 -> done in cycle 1, S=0xFFFFFFFF; REMU A=5, B=0 -> S=5.
- DIV A=0x80000000, B=0xFFFFFFFF -> done in cycle 1, S=0x80000000; REM with the same operands -> S=0.
- During a DIVU 100/7, pulse start with A=9, B=3 at cycle 10 -> ignored, S=14 at cycle 34. Then assert flush in CALC of a new operation -> no done pulse, S stays 14, busy=0 next cycle.
- Assert reset at cycle 5 of an operation -> next cycle busy=0, done=0, S=0. A new start afterwards runs normally with correct latency.
